// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM states, BCD limits, default prescaler modulus and
// the MM:SS time record with its BCD increment.
package stopwatch_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
   typedef struct packed {
      logic [3:0] m1;
      logic [3:0] m0;
      logic [3:0] s1;
      logic [3:0] s0;
   } time_t;
   localparam logic [3:0] LO_MAX = 4'd9;
   localparam logic [3:0] HI_MAX = 4'd5;
   localparam int DIV_DEFAULT = 50000000;
   localparam time_t T_MAX = '{m1: HI_MAX, m0: LO_MAX, s1: HI_MAX, s0: LO_MAX};

   function automatic time_t bcd_next(input time_t t);
      logic c0, c1, c2;
      c0 = t.s0 == LO_MAX;
      c1 = c0 && t.s1 == HI_MAX;
      c2 = c1 && t.m0 == LO_MAX;
      bcd_next.s0 = c0 ? '0 : t.s0 + 4'd1;
      bcd_next.s1 = c1 ? '0 : c0 ? t.s1 + 4'd1 : t.s1;
      bcd_next.m0 = c2 ? '0 : c1 ? t.m0 + 4'd1 : t.m0;
      bcd_next.m1 = (c2 && t.m1 == HI_MAX) ? '0 : c2 ? t.m1 + 4'd1 : t.m1;
   endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: gated modulo-DIV cycle counter; term flags the last count
// of each second.
module tick_prescaler
   import stopwatch_pkg::*;
#(
   parameter int DIV = DIV_DEFAULT
) (
   input  logic clk,
   input  logic clr_n,
   input  logic en,
   input  logic zero,
   output logic term
);
   localparam logic [26:0] LAST = 27'(DIV - 1);
   logic [26:0] pcnt;
   assign term = pcnt == LAST;
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) pcnt <= '0;
      else pcnt <= zero ? '0 : !en ? pcnt : term ? '0 : pcnt + 27'd1;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear FSM over a gated prescaler and MM:SS BCD counter.
// Define STOPWATCH_LAP_EN to add the lap display freeze.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DIV = DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] disp_sec_lo,
   output logic [3:0] disp_sec_hi,
   output logic [3:0] disp_min_lo,
   output logic [3:0] disp_min_hi,
   output logic       running,
   output logic       tick,
   output logic       wrap,
   output logic       lap_hold
);
   state_t state, state_n;
   time_t  live, live_n, disp;
   logic   term, inc;

   tick_prescaler #(.DIV(DIV)) u_pre (
      .clk  (clk),
      .clr_n(clr_n),
      .en   (state == RUN),
      .zero (state == IDLE || clear),
      .term (term)
   );

   always_comb begin
      inc     = state == RUN && term && !clear;
      state_n = clear ? IDLE : start_stop ? (state == RUN ? PAUSE : RUN) : state;
      live_n  = clear ? '0 : inc ? bcd_next(live) : live;
   end

   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) begin
         state   <= IDLE;
         live    <= '0;
         running <= 1'b0;
         tick    <= 1'b0;
         wrap    <= 1'b0;
      end else begin
         state   <= state_n;
         live    <= live_n;
         running <= state_n == RUN;
         tick    <= inc;
         wrap    <= inc && live == T_MAX;
      end

`ifdef STOPWATCH_LAP_EN
   // disp doubles as the hold register: it equals live whenever not frozen
   logic  hold_n;
   time_t disp_n;
   always_comb begin
      hold_n = clear ? 1'b0 : (lap && state == RUN) ? !lap_hold : lap_hold;
      disp_n = hold_n ? disp : live_n;
   end
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) begin
         lap_hold <= 1'b0;
         disp     <= '0;
      end else begin
         lap_hold <= hold_n;
         disp     <= disp_n;
      end
`else
   assign disp = live;
   // self-gated from a zero reset, so lap_hold stays 0 and lap has no effect
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) lap_hold <= 1'b0;
      else lap_hold <= lap_hold & lap;
`endif

   assign disp_sec_lo = disp.s0;
   assign disp_sec_hi = disp.s1;
   assign disp_min_lo = disp.m0;
   assign disp_min_hi = disp.m1;
endmodule
